wb_ram_slave: RTL
=================

Name: wb_ram_slave

Overview:
- Wishbone B3 slave holding a single-port on-chip RAM.
- It sits on the far end of the processor's instruction or data master bus and serves instruction fetch and data access.
- It supports classic cycles and registered-feedback bursts: incrementing with linear/wrap4/wrap8/wrap16 (cti/bte), with one-beat-per-cycle acknowledgement.
- Accesses outside its address window are answered with err.

Parameters:
- AW, 12, word-address bits; RAM depth = 2**AW 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte base address; must be aligned to 2**(AW+2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- wb_cyc  in  1  bus cycle valid.
- wb_stb  in  1  strobe.
- wb_we  in  1  write enable.
- wb_adr  in  32  byte address.
- wb_sel  in  4  byte selects; bit0 = dat[7:0].
- wb_dat_m2s  in  32  write data.
- wb_cti  in  3  cycle type: 000 classic, 010 incrementing, 111 end-of-burst; other values are treated as classic.
- wb_bte  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- wb_dat_s2m  out  32  read data.
- wb_ack  out  1  acknowledge.
- wb_err  out  1  error (out-of-window access).
- wb_rty  out  1  retry; tied to 0.

Behaviour:
- Request: req = wb_cyc & wb_stb.
- In-window test: hit = (wb_adr[31:AW+2] == BASE_ADDR[31:AW+2]).
- Word index: wb_adr[AW+1:2]. wb_adr[1:0] is ignored.
- Reset (asynchronous): state=IDLE, ack_q=0, err_q=0, wb_dat_s2m=0. RAM contents are not initialised or cleared.
- Output gating: wb_ack = ack_q & req; wb_err = err_q & req. A master dropping cyc/stb never sees a stale ack or err.
- RAM read port is registered with 1-cycle latency. Read address is driven by the FSM (below).
- Writes commit on any cycle with wb_ack=1 and wb_we=1. Only bytes with wb_sel[i]=1 are written, using the current wb_adr.
- Read data on a write cycle is don't-care.
- FSM states: IDLE, SINGLE, BURST, ERR.
- IDLE:
  - req & !hit -> ERR; err_q=1 next cycle.
  - req & hit -> read address = wb_adr word; ack_q=1 next cycle; state -> BURST if wb_cti==010, else SINGLE.
  - Otherwise stay.
- SINGLE:
  - ack_q=1 for exactly this cycle; next cycle ack_q=0, state -> IDLE.
  - Back-to-back classic cycles are therefore acked every other cycle (2-cycle throughput).
- BURST:
  - Each cycle with req & ack_q, compute next word address nxt from the current wb_adr word a with mask m = 3/7/15 for bte 01/10/11: nxt = (a & ~m) | ((a+1) & m). Linear: nxt = a+1, wrapping modulo 2**AW.
  - Read address = nxt, so data is ready when the master advances; ack_q stays 1.
  - wb_cti==111 on an acked beat -> ack_q=0 next cycle, state -> IDLE.
  - !req (master wait or cyc drop) -> ack_q=0, state -> IDLE. A resumed burst restarts with 1 cycle latency at the presented address.
  - !hit on the presented beat -> no ack on that beat (ack_q forced 0 combinationally); err_q=1 next cycle; state -> ERR. A linear burst crossing the window end hits this case.
- ERR: err_q=1 for one cycle, then 0; state -> IDLE.
- Simultaneous: a new req arriving in the cycle the FSM returns to IDLE is evaluated the following cycle; there are no pipelined classic overlaps.
- Reset mid-burst: ack/err drop immediately (asynchronously). Any write already committed remains in RAM.
- wb_rty is constant 0.

Test Plan:
- Reset: assert rst with req active -> wb_ack=0, wb_err=0, wb_rty=0, wb_dat_s2m=0 in the same cycle. After release with no req, outputs stay 0.
- Classic write then read: write 32'hDEADBEEF to BASE+0x10 with sel=4'hF -> ack 1 cycle after stb, high for 1 cycle. Classic read of BASE+0x10 -> wb_dat_s2m=32'hDEADBEEF with ack 1 cycle after stb.
- Byte select: write 32'h11223344 with sel=4'b0101 over 32'hDEADBEEF at BASE+0x10 -> readback 32'hDE22BE44.
- Wrap4 read burst: prefill words 0..3 with 0xA0..0xA3; start at BASE+0x0C with cti=010, bte=01, master addresses 0C,00,04,08 and cti=111 on the last beat -> acks on 4 consecutive cycles, data A3,A0,A1,A2; ack low the cycle after.
- Out-of-window: classic read at BASE+(4<<AW) -> wb_err high 1 cycle after stb for 1 cycle, no ack. Linear burst from the last word into the window end -> last in-window beat acked, next beat gets err and no ack.
- Burst interruption: drop stb mid-burst for 2 cycles, then resume -> ack low while stb is low; first resumed beat acked 1 cycle after stb; data correct for the resumed address. Async reset pulse mid-burst -> ack drops the same cycle.

Source files
------------

// File: rtl/wb_ram_slave.sv
// Wishbone B3 slave wrapping a single-port 32-bit on-chip RAM.
// Serves classic cycles and registered-feedback incrementing bursts
// (linear, wrap4, wrap8, wrap16) at one beat per cycle. Accesses outside
// the address window are answered with err instead of ack.
//
// Handshake: a request is wb_cyc & wb_stb. A beat completes on the cycle
// the slave shows wb_ack (or wb_err); the master must hold address, data,
// sel, we, cti and bte stable until then. Both responses are gated by the
// live request, so a master that drops cyc/stb never sees a stale response.
module wb_ram_slave #(
    parameter int          AW        = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic [31:0] wb_adr,
    input  logic [3:0]  wb_sel,
    input  logic [31:0] wb_dat_m2s,
    input  logic [2:0]  wb_cti,
    input  logic [1:0]  wb_bte,
    output logic [31:0] wb_dat_s2m,
    output logic        wb_ack,
    output logic        wb_err,
    output logic        wb_rty
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SINGLE = 2'd1,
        BURST  = 2'd2,
        ERR    = 2'd3
    } state_t;

    // Current FSM state; kept as a named signal so checkers can bind to it.
    state_t        state;
    logic          ack_q;
    logic          err_q;

    logic          req;
    logic          hit;
    logic [AW-1:0] word;
    logic [AW-1:0] word_inc;
    logic [AW-1:0] wrap_mask;
    logic [AW-1:0] nxt;
    logic [AW-1:0] rd_addr;
    logic [31:0]   mem [0:DEPTH-1];

    // Byte-lane bits of the address carry no information for a word RAM.
    logic          unused_adr_bits;
    assign unused_adr_bits = ^wb_adr[1:0];

    assign req      = wb_cyc & wb_stb;
    assign hit      = (wb_adr[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign word     = wb_adr[AW+1:2];
    assign word_inc = word + AW'(1);

    // Bits of the word address that advance during a burst; the rest stay fixed.
    always_comb begin
        wrap_mask = '1;
        case (wb_bte)
            2'b01:   wrap_mask = AW'(3);
            2'b10:   wrap_mask = AW'(7);
            2'b11:   wrap_mask = AW'(15);
            default: wrap_mask = '1;
        endcase
    end

    // Inside a burst the RAM is pre-read at the address the master will
    // present next, so the data is already registered when it advances.
    assign nxt     = (word & ~wrap_mask) | (word_inc & wrap_mask);
    assign rd_addr = (state == BURST) ? nxt : word;

    // An out-of-window beat is never acked, even while ack_q is still high.
    assign wb_ack = ack_q & req & hit;
    assign wb_err = err_q & req;
    assign wb_rty = 1'b0;

    // Control FSM: sequences classic/burst acks and one-cycle error responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                    if (req) begin
                        if (!hit) begin
                            err_q <= 1'b1;
                            state <= ERR;
                        end else begin
                            ack_q <= 1'b1;
                            state <= (wb_cti == 3'b010) ? BURST : SINGLE;
                        end
                    end
                end
                SINGLE: begin
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                    state <= IDLE;
                end
                BURST: begin
                    err_q <= 1'b0;
                    if (!req) begin
                        ack_q <= 1'b0;
                        state <= IDLE;
                    end else if (!hit) begin
                        ack_q <= 1'b0;
                        err_q <= 1'b1;
                        state <= ERR;
                    end else if (wb_cti == 3'b111) begin
                        ack_q <= 1'b0;
                        state <= IDLE;
                    end else begin
                        ack_q <= 1'b1;
                    end
                end
                ERR: begin
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Registered read port: one cycle from address to wb_dat_s2m.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_dat_s2m <= '0;
        end else begin
            wb_dat_s2m <= mem[rd_addr];
        end
    end

    // Byte-masked write on every acknowledged write beat; RAM is never cleared.
    always_ff @(posedge clk) begin
        if (wb_ack && wb_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wb_sel[i]) begin
                    mem[word][8*i +: 8] <= wb_dat_m2s[8*i +: 8];
                end
            end
        end
    end

endmodule
